// File: rtl/operand_stack_pkg.sv
// Shared definitions for the operand stack: operation encodings and sizing helpers.
package operand_stack_pkg;

   localparam int unsigned OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_NOP     = 3'b000,
      OP_PUSH    = 3'b001,
      OP_POP     = 3'b010,
      OP_LOAD    = 3'b011,
      OP_POPLOAD = 3'b100,
      OP_DUP     = 3'b101
   } stack_op_e;

   // Counter width able to hold every value 0..depth inclusive.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/operand_stack_if.sv
// Control-unit/ALU facing bundle of the operand stack.
interface operand_stack_if
   import operand_stack_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned PW    = 5
);

   logic [OP_W-1:0]  op;
   logic [WIDTH-1:0] d;
   logic             clr_err;
   logic [WIDTH-1:0] qtop;
   logic [WIDTH-1:0] qnext;
   logic [PW-1:0]    count;
   logic             empty;
   logic             full;
   logic             ovf;
   logic             unf;

   modport master (
      output op, d, clr_err,
      input  qtop, qnext, count, empty, full, ovf, unf
   );

   modport slave (
      input  op, d, clr_err,
      output qtop, qnext, count, empty, full, ovf, unf
   );

endinterface

// File: rtl/operand_stack_ram.sv
// DEPTH x WIDTH register array: one synchronous write port, one combinational read port.
module operand_stack_ram #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // NOTE: the array has no reset; entries above count are never observed, so clearing them buys nothing.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/operand_stack.sv
// Operand stack feeding the ALU: shadow top/next registers over a register array, sticky error flags.
module operand_stack
   import operand_stack_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned PW    = cnt_width(DEPTH)
) (
   input  logic           clk,
   input  logic           n_reset,
   operand_stack_if.slave bus
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [PW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] top_q, top_d;
   logic [WIDTH-1:0] next_q, next_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   logic             ram_we;
   logic [AW-1:0]    ram_waddr;
   logic [WIDTH-1:0] ram_wdata;
   logic [AW-1:0]    ram_raddr;
   logic [WIDTH-1:0] ram_rdata;

   logic             is_empty;
   logic             is_full;
   logic             has_third;
   logic [AW-1:0]    ptr;

   assign is_empty  = (count_q == '0);
   assign is_full   = (count_q == PW'(DEPTH));
   assign has_third = (count_q >= PW'(3));
   // Modular address math on the low bits stays correct even when count equals a power-of-two DEPTH.
   assign ptr       = count_q[AW-1:0];
   assign ram_raddr = ptr - AW'(3);

   operand_stack_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .waddr_i (ram_waddr),
      .wdata_i (ram_wdata),
      .raddr_i (ram_raddr),
      .rdata_o (ram_rdata)
   );

   // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
   always_comb begin
      count_d   = count_q;
      top_d     = top_q;
      next_d    = next_q;
      ovf_d     = ovf_q & ~bus.clr_err;
      unf_d     = unf_q & ~bus.clr_err;
      ram_we    = 1'b0;
      ram_waddr = ptr;
      ram_wdata = bus.d;

      case (bus.op)
         OP_PUSH: begin
            if (is_full) begin
               ovf_d = 1'b1;
            end else begin
               ram_we  = 1'b1;
               top_d   = bus.d;
               next_d  = top_q;
               count_d = count_q + PW'(1);
            end
         end
         OP_DUP: begin
            if (is_full) begin
               ovf_d = 1'b1;
            end else if (is_empty) begin
               unf_d = 1'b1;
            end else begin
               ram_we    = 1'b1;
               ram_wdata = top_q;
               next_d    = top_q;
               count_d   = count_q + PW'(1);
            end
         end
         OP_POP: begin
            if (is_empty) begin
               unf_d = 1'b1;
            end else begin
               top_d   = next_q;
               next_d  = has_third ? ram_rdata : '0;
               count_d = count_q - PW'(1);
            end
         end
         OP_LOAD: begin
            if (is_empty) begin
               unf_d = 1'b1;
            end else begin
               ram_we    = 1'b1;
               ram_waddr = ptr - AW'(1);
               top_d     = bus.d;
            end
         end
         OP_POPLOAD: begin
            if (count_q < PW'(2)) begin
               unf_d = 1'b1;
            end else begin
               ram_we    = 1'b1;
               ram_waddr = ptr - AW'(2);
               top_d     = bus.d;
               next_d    = has_third ? ram_rdata : '0;
               count_d   = count_q - PW'(1);
            end
         end
         default: ;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!n_reset) begin
         count_q <= '0;
         top_q   <= '0;
         next_q  <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         top_q   <= top_d;
         next_q  <= next_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign bus.qtop  = top_q;
   assign bus.qnext = next_q;
   assign bus.count = count_q;
   assign bus.empty = is_empty;
   assign bus.full  = is_full;
   assign bus.ovf   = ovf_q;
   assign bus.unf   = unf_q;

endmodule

// File: tb/tb_operand_stack.sv
// Scoreboard bench for operand_stack: queue-based reference stack, directed plan then random traffic.
module tb_operand_stack;
   import operand_stack_pkg::*;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned PW    = 5;

   typedef struct {
      logic [WIDTH-1:0] top;
      logic [WIDTH-1:0] nxt;
      int unsigned      cnt;
      bit               ovf;
      bit               unf;
   } exp_t;

   logic clk;
   logic n_reset;

   operand_stack_if #(.WIDTH(WIDTH), .PW(PW)) bus ();

   operand_stack #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .PW    (PW)
   ) dut (
      .clk     (clk),
      .n_reset (n_reset),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t exp_q[$];

   logic [WIDTH-1:0] m_stack[$];
   bit               m_ovf;
   bit               m_unf;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: a plain queue of words, top at the back.
   task automatic model(input logic [2:0] op, input logic [WIDTH-1:0] d, input bit clr, input bit rst);
      int unsigned n;
      if (rst) begin
         m_stack.delete();
         m_ovf = 0;
         m_unf = 0;
         return;
      end
      if (clr) begin
         m_ovf = 0;
         m_unf = 0;
      end
      n = m_stack.size();
      case (op)
         3'b001: if (n == DEPTH) m_ovf = 1; else m_stack.push_back(d);
         3'b010: if (n == 0) m_unf = 1; else void'(m_stack.pop_back());
         3'b011: if (n == 0) m_unf = 1; else m_stack[n-1] = d;
         3'b100: begin
            if (n < 2) m_unf = 1;
            else begin
               void'(m_stack.pop_back());
               m_stack[n-2] = d;
            end
         end
         3'b101: begin
            if (n == DEPTH) m_ovf = 1;
            else if (n == 0) m_unf = 1;
            else m_stack.push_back(m_stack[n-1]);
         end
         default: ;
      endcase
   endtask

   function automatic exp_t snapshot();
      exp_t e;
      int unsigned n;
      n     = m_stack.size();
      e.cnt = n;
      e.top = (n >= 1) ? m_stack[n-1] : '0;
      e.nxt = (n >= 2) ? m_stack[n-2] : '0;
      e.ovf = m_ovf;
      e.unf = m_unf;
      return e;
   endfunction

   task automatic step(input logic [2:0] op, input logic [WIDTH-1:0] d, input bit clr = 0, input bit rst = 0);
      @(negedge clk);
      bus.op      = op;
      bus.d       = d;
      bus.clr_err = clr;
      n_reset     = ~rst;
      model(op, d, clr, rst);
      exp_q.push_back(snapshot());
   endtask

   // Monitor: every edge with an outstanding expectation is compared just after the edge.
   initial begin
      exp_t e;
      int   cyc;
      cyc = 0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("cyc%0d qtop", cyc),  32'(bus.qtop),  32'(e.top));
            check($sformatf("cyc%0d qnext", cyc), 32'(bus.qnext), 32'(e.nxt));
            check($sformatf("cyc%0d count", cyc), 32'(bus.count), e.cnt);
            check($sformatf("cyc%0d empty", cyc), 32'(bus.empty), 32'(e.cnt == 0));
            check($sformatf("cyc%0d full", cyc),  32'(bus.full),  32'(e.cnt == DEPTH));
            check($sformatf("cyc%0d ovf", cyc),   32'(bus.ovf),   32'(e.ovf));
            check($sformatf("cyc%0d unf", cyc),   32'(bus.unf),   32'(e.unf));
         end
      end
   end

   initial begin
      int unsigned r;
      logic [2:0]  op;
      bus.op      = OP_NOP;
      bus.d       = '0;
      bus.clr_err = 1'b0;
      n_reset     = 1'b0;

      // Reset then idle.
      step(OP_NOP, 16'h0, 0, 1);
      step(OP_NOP, 16'h0, 0, 1);
      step(OP_NOP, 16'h0);

      // Binary ALU op write-back.
      step(OP_PUSH, 16'h0003);
      step(OP_PUSH, 16'h0005);
      step(OP_POPLOAD, 16'h0002);
      step(OP_POP, 16'h0);

      // Deep refill of qnext from the array.
      for (int i = 1; i <= 4; i++) step(OP_PUSH, 16'(i));
      step(OP_POPLOAD, 16'h00AA);
      step(OP_POP, 16'h0);

      // Overflow and clear.
      step(OP_NOP, 16'h0, 0, 1);
      for (int i = 1; i <= DEPTH; i++) step(OP_PUSH, 16'(i));
      step(OP_PUSH, 16'hFFFF);
      step(OP_DUP, 16'h0);
      step(OP_NOP, 16'h0, 1);
      step(OP_POP, 16'h0);
      step(OP_POPLOAD, 16'h5A5A);

      // Underflow, set-wins-over-clear.
      step(OP_NOP, 16'h0, 0, 1);
      step(OP_POP, 16'h0);
      step(OP_PUSH, 16'h0007);
      step(OP_POPLOAD, 16'h0009);
      step(OP_POP, 16'h0);
      step(OP_POP, 16'h0, 1);
      step(OP_LOAD, 16'h1111);
      step(OP_DUP, 16'h0);
      step(OP_NOP, 16'h0, 1);

      // LOAD/DUP then reset with a concurrent PUSH.
      step(OP_PUSH, 16'h1234);
      step(OP_DUP, 16'h0);
      step(OP_LOAD, 16'hEDCB);
      step(3'b110, 16'hBEEF);
      step(3'b111, 16'hBEEF);
      step(OP_PUSH, 16'h4321, 0, 1);
      step(OP_NOP, 16'h0);

      // Random traffic alternating between filling and draining phases.
      for (int i = 0; i < 1600; i++) begin
         r = $urandom_range(0, 99);
         if (((i / 80) % 2) == 0) begin
            op = (r < 55) ? 3'b001 : (r < 65) ? 3'b101 : (r < 75) ? 3'b011 :
                 (r < 85) ? 3'b010 : (r < 93) ? 3'b100 : 3'(r % 8);
         end else begin
            op = (r < 35) ? 3'b010 : (r < 65) ? 3'b100 : (r < 75) ? 3'b011 :
                 (r < 85) ? 3'b001 : (r < 90) ? 3'b101 : 3'(r % 8);
         end
         step(op, 16'($urandom), ($urandom_range(0, 15) == 0), ($urandom_range(0, 299) == 0));
      end
      step(OP_NOP, 16'h0);

      repeat (10) begin
         if (exp_q.size() == 0) break;
         @(posedge clk);
      end
      #2;
      check("drain", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
